// File: rtl/clken_gen.sv
// Multi-channel phase-accumulator clock-enable generator with lock indication.
// Optional build macro CLKEN_GEN_PHASE_ALIGN_EN: every valid write restarts all channels phase-aligned.
module clken_gen #(
    parameter int NUM_CH   = 2,
    parameter int ACC_W    = 24,
    parameter int LOCK_CYC = 16,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT  = {NUM_CH{1'b1, {(ACC_W-1){1'b0}}}},
    parameter logic [NUM_CH-1:0]       MODE_INIT = '0,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_mode,
    output logic              cfg_ack,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam logic [7:0]    LOCK_L   = 8'(LOCK_CYC);

    logic [ACC_W-1:0]  acc_q  [NUM_CH];
    logic [ACC_W-1:0]  acc_d  [NUM_CH];
    logic [ACC_W-1:0]  inc_q  [NUM_CH];
    logic [ACC_W-1:0]  inc_d  [NUM_CH];
    logic [ACC_W:0]    sum_w  [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic              ack_q, ack_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic              wr_valid;

    always_comb begin
        wr_valid = cfg_wr & ({1'b0, cfg_ch} < NUM_CH_L);
        mode_d   = mode_q;
        ce_d     = '0;
        clk_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_w[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            acc_d[i] = sum_w[i][ACC_W-1:0];
            inc_d[i] = inc_q[i];
            ce_d[i]  = sum_w[i][ACC_W];
            // square clock only runs in mode 1; a channel leaving mode 0 is already at 0
            clk_d[i] = mode_q[i] & (clk_q[i] ^ sum_w[i][ACC_W]);
            if (wr_valid && (cfg_ch == CH_W'(i))) begin
                inc_d[i]  = cfg_inc;
                mode_d[i] = cfg_mode;
                if (!cfg_mode) begin
                    clk_d[i] = 1'b0;
                end
            end
`ifdef CLKEN_GEN_PHASE_ALIGN_EN
            if (wr_valid) begin
                acc_d[i] = '0;
                clk_d[i] = 1'b0;
            end
`endif
        end

        ack_d = cfg_wr;

        // lock timer: down-counter, terminal count zero means locked
        if (wr_valid) begin
            lock_cnt_d = LOCK_L;
        end else if (lock_cnt_q != 8'd0) begin
            lock_cnt_d = lock_cnt_q - 8'd1;
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
        locked_d = (lock_cnt_d == 8'd0);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
            end
            mode_q     <= MODE_INIT;
            ce_q       <= '0;
            clk_q      <= '0;
            ack_q      <= 1'b0;
            lock_cnt_q <= LOCK_L;
            locked_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
            mode_q     <= mode_d;
            ce_q       <= ce_d;
            clk_q      <= clk_d;
            ack_q      <= ack_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign cfg_ack = ack_q;
    assign ce      = ce_q;
    assign clk_out = clk_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_clken_gen.sv
// Randomized bench for clken_gen against a cycle-level arithmetic reference model, plus literal checks.
module tb_clken_gen;

    localparam int NCH = 3;
    localparam int AW  = 8;
    localparam int LC  = 16;
    localparam longint MODV = longint'(1) << AW;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_wr;
    logic [1:0]     cfg_ch;
    logic [AW-1:0]  cfg_inc;
    logic           cfg_mode;
    logic           cfg_ack;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] clk_out;
    logic           locked;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    clken_gen #(
        .NUM_CH(NCH), .ACC_W(AW), .LOCK_CYC(LC),
        .INC_INIT({8'd32, 8'd128, 8'd64}), .MODE_INIT(3'b010)
    ) dut (
        .refclk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc), .cfg_mode(cfg_mode), .cfg_ack(cfg_ack),
        .ce(ce), .clk_out(clk_out), .locked(locked)
    );

    always #5 clk = ~clk;

    // reference model: accumulators as plain integers, lock as cycles since last (re)start
    longint m_acc [NCH];
    longint m_inc [NCH];
    bit     m_mode[NCH];
    bit     m_clk [NCH];
    bit     m_ce  [NCH];
    bit     m_ack, m_locked;
    int     m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_inc[0] = 64; m_inc[1] = 128; m_inc[2] = 32;
            m_mode[0] = 0; m_mode[1] = 1; m_mode[2] = 0;
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0; m_clk[i] = 0; m_ce[i] = 0;
            end
            m_ack = 0; m_locked = 0; m_cnt = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                longint s;
                s = m_acc[i] + m_inc[i];
                m_ce[i]  = (s >= MODV);
                m_acc[i] = s % MODV;
                if (m_mode[i]) m_clk[i] = m_clk[i] ^ m_ce[i];
                else           m_clk[i] = 0;
            end
            m_ack = cfg_wr;
            m_cnt++;
            if (cfg_wr && int'(cfg_ch) < NCH) begin
                int c;
                c = int'(cfg_ch);
                m_inc[c] = longint'(cfg_inc);
                if (!cfg_mode) m_clk[c] = 0;
                m_mode[c] = cfg_mode;
                m_cnt = 0;
`ifdef CLKEN_GEN_PHASE_ALIGN_EN
                for (int i = 0; i < NCH; i++) begin
                    m_acc[i] = 0; m_clk[i] = 0;
                end
`endif
            end
            m_locked = (m_cnt >= LC);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NCH; i++) begin
                n_checks++;
                if (ce[i] !== m_ce[i]) begin
                    n_errors++;
                    $display("FAIL model_ce[%0d] t=%0t got %b exp %b", i, $time, ce[i], m_ce[i]);
                end
                n_checks++;
                if (clk_out[i] !== m_clk[i]) begin
                    n_errors++;
                    $display("FAIL model_clk_out[%0d] t=%0t got %b exp %b", i, $time, clk_out[i], m_clk[i]);
                end
            end
            n_checks++;
            if (cfg_ack !== m_ack) begin
                n_errors++;
                $display("FAIL model_cfg_ack t=%0t got %b exp %b", $time, cfg_ack, m_ack);
            end
            n_checks++;
            if (locked !== m_locked) begin
                n_errors++;
                $display("FAIL model_locked t=%0t got %b exp %b", $time, locked, m_locked);
            end
        end
    end

    task automatic ck(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got %0d exp %0d", name, $time, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // drives one write, returns at the ack sample point
    task automatic wr(input int ch, input int inc, input bit mode);
        cfg_wr = 1; cfg_ch = 2'(ch); cfg_inc = AW'(inc); cfg_mode = mode;
        cyc();
        cfg_wr = 0;
    endtask

    initial begin
        int first0, first1, cnt;
        rst = 1; cfg_wr = 0; cfg_ch = 0; cfg_inc = 0; cfg_mode = 0;
        repeat (3) cyc();
        // write concurrent with reset must be discarded
        cfg_wr = 1; cfg_ch = 0; cfg_inc = 8'd255; cfg_mode = 1;
        cyc();
        rst = 0; cfg_wr = 0; chk_en = 1;
        ck("ack_after_rst_wr", cfg_ack, 0);
        ck("locked_in_reset", locked, 0);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            ck($sformatf("ce0_k%0d", k), ce[0], (k % 4 == 0) ? 1 : 0);
            ck($sformatf("ce2_k%0d", k), ce[2], (k % 8 == 0) ? 1 : 0);
            ck($sformatf("clk0_k%0d", k), clk_out[0], 0);
            ck($sformatf("clk1_k%0d", k), clk_out[1], (k / 2) % 2);
            ck($sformatf("lock_k%0d", k), locked, (k >= 16) ? 1 : 0);
        end

        wr(0, 64, 0);
        ck("ack_valid", cfg_ack, 1);
        ck("lock_drop", locked, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            ck($sformatf("relock_k%0d", k), locked, (k >= 16) ? 1 : 0);
        end
        wr(3, 7, 1);
        ck("ack_invalid", cfg_ack, 1);
        ck("lock_keep_invalid", locked, 1);

        // back-to-back on ch1: the second write wins
        cfg_wr = 1; cfg_ch = 1; cfg_inc = 8'd200; cfg_mode = 0;
        cyc();
        cfg_inc = 8'd96; cfg_mode = 1;
        cyc();
        cfg_wr = 0;
        repeat ($urandom_range(5, 20)) cyc();
        wr(2, 32, 0);
        first0 = 0; first1 = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (ce[0] && first0 == 0) first0 = k;
            if (ce[1] && first1 == 0) first1 = k;
        end
`ifdef CLKEN_GEN_PHASE_ALIGN_EN
        ck("align_first_ce0", first0, 4);
        ck("align_first_ce1", first1, 3);
`endif

        wr(0, 255, 0);
        cnt = 0;
        for (int k = 1; k <= 256; k++) begin
            cyc();
            cnt += int'(ce[0]);
        end
        ck("rate_inc255", cnt, 255);

        wr(0, 0, 1);
        cnt = 0;
        for (int k = 1; k <= 1000; k++) begin
            cyc();
            cnt += int'(ce[0]) + int'(clk_out[0]);
        end
        ck("rate_inc0", cnt, 0);

        for (int n = 0; n < 3000; n++) begin
            int sel;
            rst = ($urandom_range(0, 199) == 0);
            cfg_wr = ($urandom_range(0, 5) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            cfg_inc = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : (sel == 2) ? 8'd128 : 8'($urandom);
            cfg_mode = 1'($urandom_range(0, 1));
            cyc();
        end
        rst = 0; cfg_wr = 0;
        repeat (40) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
